// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide controller for DIV/DIVU in the EXE stage.
// Produces one quotient bit per cycle and holds the pipeline until the result is ready.
// The quotient goes to lo and the remainder goes to hi.
module div_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              div_start,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_dividend,
    input  logic [DATA_W-1:0] div_divisor,
    input  logic              div_cancel,
    output logic              stall_req,
    output logic              div_busy,
    output logic              div_done,
    output logic [DATA_W-1:0] div_quot,
    output logic [DATA_W-1:0] div_rem
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        StIdle,
        StDzero,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    // Working dividend; quotient bits shift in at the LSB as dividend bits leave at the MSB.
    logic [DATA_W-1:0]  wquot_q, wquot_d;
    logic [DATA_W-1:0]  wrem_q, wrem_d;
    logic [DATA_W-1:0]  dsr_q, dsr_d;
    logic               sign_q_q, sign_q_d;
    logic               sign_r_q, sign_r_d;
    logic [DATA_W-1:0]  res_quot_q, res_quot_d;
    logic [DATA_W-1:0]  res_rem_q, res_rem_d;

    logic [DATA_W-1:0]  partial;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  step_rem;
    logic [DATA_W-1:0]  step_quot;
    logic [DATA_W-1:0]  dnd_abs;
    logic [DATA_W-1:0]  dsr_abs;

    // One restoring step plus absolute-value conversion of the incoming operands.
    always_comb begin
        // After i steps the partial remainder holds at most i significant bits,
        // so dropping wrem_q's MSB loses nothing.
        partial   = {wrem_q[DATA_W-2:0], wquot_q[DATA_W-1]};
        diff      = {1'b0, partial} - {1'b0, dsr_q};
        step_rem  = diff[DATA_W] ? partial : diff[DATA_W-1:0];
        step_quot = {wquot_q[DATA_W-2:0], ~diff[DATA_W]};
        dnd_abs   = (div_signed && div_dividend[DATA_W-1]) ? -div_dividend : div_dividend;
        dsr_abs   = (div_signed && div_divisor[DATA_W-1]) ? -div_divisor : div_divisor;
    end

    // Next-state and datapath register updates; cancel overrides everything.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wquot_d    = wquot_q;
        wrem_d     = wrem_q;
        dsr_d      = dsr_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;

        unique case (state_q)
            StIdle: begin
                if (div_start && !div_cancel) begin
                    if (div_divisor == '0) begin
                        state_d = StDzero;
                        // Keep the raw dividend; it becomes the remainder unchanged.
                        wquot_d = div_dividend;
                    end else begin
                        state_d  = StRun;
                        wquot_d  = dnd_abs;
                        dsr_d    = dsr_abs;
                        wrem_d   = '0;
                        count_d  = '0;
                        sign_q_d = div_signed & (div_dividend[DATA_W-1] ^ div_divisor[DATA_W-1]);
                        sign_r_d = div_signed & div_dividend[DATA_W-1];
                    end
                end
            end
            StDzero: begin
                state_d    = StDone;
                res_quot_d = '1;
                res_rem_d  = wquot_q;
            end
            StRun: begin
                wquot_d = step_quot;
                wrem_d  = step_rem;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DATA_W - 1)) begin
                    state_d    = StDone;
                    res_quot_d = sign_q_q ? -step_quot : step_quot;
                    res_rem_d  = sign_r_q ? -step_rem : step_rem;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (div_cancel) begin
            state_d    = StIdle;
            res_quot_d = res_quot_q;
            res_rem_d  = res_rem_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wquot_q    <= '0;
            wrem_q     <= '0;
            dsr_q      <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wquot_q    <= wquot_d;
            wrem_q     <= wrem_d;
            dsr_q      <= dsr_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
        end
    end

    // Status and result outputs; stall drops in DONE so EXE advances with the result.
    always_comb begin
        div_busy  = (state_q != StIdle);
        div_done  = (state_q == StDone);
        stall_req = !div_cancel &&
                    (((state_q == StIdle) && div_start) ||
                     (state_q == StDzero) || (state_q == StRun));
        div_quot  = res_quot_q;
        div_rem   = res_rem_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl (DATA_W = 32).
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] div_dividend = '0;
    logic [31:0] div_divisor = '0;
    logic        div_cancel = 1'b0;
    logic        stall_req;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_ctrl #(.DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_cancel  (div_cancel),
        .stall_req   (stall_req),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .div_quot    (div_quot),
        .div_rem     (div_rem)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called just after a negedge. Cycle 0 is the start cycle; outputs sampled 1ns
    // after each negedge. hold keeps div_start high until the DONE cycle.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] dnd,
                          input logic [31:0] dsr, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int done_cyc, input logic hold);
        int done_at = -1;
        int done_cnt = 0;
        int stall_bad = 0;
        logic [31:0] q_seen = 'x;
        logic [31:0] r_seen = 'x;
        div_start    = 1'b1;
        div_signed   = sgn;
        div_dividend = dnd;
        div_divisor  = dsr;
        for (int c = 0; c <= done_cyc + 2; c++) begin
            #1;
            if (div_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    q_seen  = div_quot;
                    r_seen  = div_rem;
                end
            end
            if (stall_req !== (c < done_cyc)) stall_bad++;
            @(negedge clk);
            if (!hold || c == done_cyc) div_start = 1'b0;
        end
        chk({tag, "_done_cycle"}, done_at, done_cyc);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_stall_bad_cycles"}, stall_bad, 0);
        chk({tag, "_quot"}, q_seen, exp_q);
        chk({tag, "_rem"}, r_seen, exp_r);
    endtask

    initial begin
        int done_cnt;

        // Reset state
        #3;
        chk("rst_stall", stall_req, 0);
        chk("rst_busy", div_busy, 0);
        chk("rst_done", div_done, 0);
        chk("rst_quot", div_quot, 0);
        chk("rst_rem", div_rem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned and signed divides
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);

        // Divide by zero
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, 1'b0);

        // Overflow and max-value boundaries
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        do_div("divu_max_big", 1'b0, 32'hFFFF_FFFF, 32'hC000_0000, 32'd1, 32'h3FFF_FFFF, 33, 1'b0);

        // Back-to-back start with div_start held through busy states
        do_div("divu_hold", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);

        // Cancel in cycle 10 of RUN
        div_start    = 1'b1;
        div_signed   = 1'b0;
        div_dividend = 32'd1000;
        div_divisor  = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            div_start = 1'b0;
        end
        div_cancel = 1'b1;
        #1;
        chk("cancel_stall_drop", stall_req, 0);
        chk("cancel_busy_same_cycle", div_busy, 1);
        @(negedge clk);
        div_cancel = 1'b0;
        #1;
        chk("cancel_busy_next", div_busy, 0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (div_done === 1'b1) done_cnt++;
            @(negedge clk);
            #1;
        end
        chk("cancel_no_done", done_cnt, 0);
        chk("cancel_quot_hold", div_quot, 32'd14);
        chk("cancel_rem_hold", div_rem, 32'd2);
        @(negedge clk);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

        // Asynchronous reset mid-RUN
        do_div("divu_77_5", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 33, 1'b0);
        div_start    = 1'b1;
        div_dividend = 32'd50;
        div_divisor  = 32'd4;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            div_start = 1'b0;
        end
        #2;
        chk("midrun_busy_before", div_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall_req, 0);
        chk("arst_busy", div_busy, 0);
        chk("arst_done", div_done, 0);
        chk("arst_quot", div_quot, 0);
        chk("arst_rem", div_rem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_busy", div_busy, 0);
        @(negedge clk);
        do_div("divu_50_4", 1'b0, 32'd50, 32'd4, 32'd12, 32'd2, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
